opsum_wb_drain: RTL and testbench

// Downstream consumer of the opsum FIFO bank (the FIFOs whose push enables come from the opsum mask).

---
 rtl/opsum_wb_drain.sv | 221 ++++++++++++++++++++++
 tb/tb_opsum_wb_drain.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opsum_wb_drain.sv
// opsum_wb_drain: drains the opsum FIFO bank into the GLB write port.
// Active FIFOs are serviced round-robin, one word per GLB write. Each word
// goes to base + lane*stride + element. done_o pulses once every active
// lane has written its quota for the tile.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start_i, clear_i    begin tile (IDLE only) / synchronous flush
//   layer_type_i        LT_PW or LT_DW; any other code leaves no lane active
//   OC_real_i           pointwise active lane count (values above NUM_FIFO clamp)
//   elems_per_oc_i      words per active lane per tile
//   base_addr_i         GLB word address of lane 0, element 0
//   oc_stride_i         address step between lanes
//   opsum_fifo_*        FIFO empty flags, FWFT head words, one-hot pop
//   glb_we_o/addr/wdata GLB write request; accepted when glb_ready_i is high
//   busy_o, done_o      tile in progress / 1-cycle completion pulse

// Per-lane element counter and eligibility.
module opsum_wb_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zero_i,
    input  logic             inc_i,
    input  logic             act_i,
    input  logic             empty_i,
    input  logic [CNT_W-1:0] elems_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             elig_o,
    output logic             quota_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zero_i)     cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    // Inactive lanes count as finished so they never hold up done_o.
    assign quota_o = ~act_i | (cnt_q >= elems_i);
    assign elig_o  = act_i & ~empty_i & (cnt_q < elems_i);
endmodule

module opsum_wb_drain #(
    parameter int         NUM_FIFO = 32,
    parameter int         DATA_W   = 16,
    parameter int         ADDR_W   = 32,
    parameter int         CNT_W    = 16,
    parameter int         DW_CH    = 10,
    parameter logic [1:0] LT_PW    = 2'd0,
    parameter logic [1:0] LT_DW    = 2'd1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       clear_i,
    input  logic [1:0]                 layer_type_i,
    input  logic [7:0]                 OC_real_i,
    input  logic [CNT_W-1:0]           elems_per_oc_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [ADDR_W-1:0]          oc_stride_i,
    input  logic [NUM_FIFO-1:0]        opsum_fifo_empty_i,
    input  logic [NUM_FIFO*DATA_W-1:0] opsum_fifo_data_i,
    output logic [NUM_FIFO-1:0]        opsum_fifo_pop_o,
    output logic                       glb_we_o,
    output logic [ADDR_W-1:0]          glb_addr_o,
    output logic [DATA_W-1:0]          glb_wdata_o,
    input  logic                       glb_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int IDX_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_FIFO-1:0] act_q, act_d;
    logic [CNT_W-1:0]    elems_q, elems_d;
    logic [ADDR_W-1:0]   base_q, base_d, stride_q, stride_d, addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [NUM_FIFO-1:0]             act_start, elig, quota, pop;
    logic [NUM_FIFO-1:0][CNT_W-1:0]  cnt;
    logic [NUM_FIFO-1:0][DATA_W-1:0] head;
    logic                            done, zero_cnt, pick_vld, all_done;
    logic [IDX_W-1:0]                pick_idx;

    assign head     = opsum_fifo_data_i;
    assign all_done = &quota;

    // Active mask sampled at start; comparing against the raw 8-bit count
    // clamps OC_real_i above NUM_FIFO to "all lanes".
    always_comb begin
        act_start = '0;
        for (int k = 0; k < NUM_FIFO; k++) begin
            if (layer_type_i == LT_PW)      act_start[k] = (k < int'(OC_real_i));
            else if (layer_type_i == LT_DW) act_start[k] = (k < DW_CH);
        end
    end

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_lane
        opsum_wb_lane #(.CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .zero_i  (zero_cnt),
            .inc_i   (pop[g]),
            .act_i   (act_q[g]),
            .empty_i (opsum_fifo_empty_i[g]),
            .elems_i (elems_q),
            .cnt_o   (cnt[g]),
            .elig_o  (elig[g]),
            .quota_o (quota[g])
        );
    end

    // First eligible lane at or after the rr pointer, wrapping.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            j = (int'(rr_q) + i) % NUM_FIFO;
            if (!pick_vld && elig[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        act_d    = act_q;
        elems_d  = elems_q;
        base_d   = base_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pop      = '0;
        done     = 1'b0;
        zero_cnt = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_SCAN;
                    act_d    = act_start;
                    elems_d  = elems_per_oc_i;
                    base_d   = base_addr_i;
                    stride_d = oc_stride_i;
                    zero_cnt = 1'b1;
                end
            end
            S_SCAN: begin
                if (all_done) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (pick_vld) begin
                    pop[pick_idx] = 1'b1;
                    // Lane product is full ADDR_W and wraps with the sum.
                    addr_d  = base_q + ADDR_W'(pick_idx) * stride_q + ADDR_W'(cnt[pick_idx]);
                    wdata_d = head[pick_idx];
                    rr_d    = (pick_idx == IDX_W'(NUM_FIFO - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (glb_ready_i) state_d = S_SCAN;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over start and over an accept in the same cycle.
        if (clear_i) begin
            state_d  = S_IDLE;
            rr_d     = '0;
            addr_d   = '0;
            wdata_d  = '0;
            pop      = '0;
            done     = 1'b0;
            zero_cnt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            act_q    <= '0;
            elems_q  <= '0;
            base_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            act_q    <= act_d;
            elems_q  <= elems_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign opsum_fifo_pop_o = pop;
    assign done_o           = done;
    assign glb_we_o         = (state_q == S_WRITE);
    assign glb_addr_o       = addr_q;
    assign glb_wdata_o      = wdata_q;
    assign busy_o           = (state_q != S_IDLE);
endmodule

// File: tb/tb_opsum_wb_drain.sv
module tb_opsum_wb_drain;
    localparam int NF = 32, DW = 16, AW = 32, CW = 16, DWCH = 10;
    localparam logic [1:0] PW = 2'd0, DWL = 2'd1;

    logic clk, rst_n, start_i, clear_i, glb_we_o, glb_ready_i, busy_o, done_o;
    logic [1:0] layer_type_i;
    logic [7:0] OC_real_i;
    logic [CW-1:0] elems_per_oc_i;
    logic [AW-1:0] base_addr_i, oc_stride_i, glb_addr_o;
    logic [NF-1:0] opsum_fifo_empty_i, opsum_fifo_pop_o;
    logic [NF*DW-1:0] opsum_fifo_data_i;
    logic [DW-1:0] glb_wdata_o;

    opsum_wb_drain dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
        .layer_type_i(layer_type_i), .OC_real_i(OC_real_i), .elems_per_oc_i(elems_per_oc_i),
        .base_addr_i(base_addr_i), .oc_stride_i(oc_stride_i),
        .opsum_fifo_empty_i(opsum_fifo_empty_i), .opsum_fifo_data_i(opsum_fifo_data_i),
        .opsum_fifo_pop_o(opsum_fifo_pop_o), .glb_we_o(glb_we_o), .glb_addr_o(glb_addr_o),
        .glb_wdata_o(glb_wdata_o), .glb_ready_i(glb_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end

    int n_chk = 0, n_err = 0;
    logic [DW-1:0] fq[NF][$];            // FIFO bank contents, head at [0]
    logic [AW-1:0] acc_addr[$], exp_addr[$];
    logic [DW-1:0] acc_data[$], exp_data[$];
    logic [NF-1:0] tb_act;
    int viol, npops, ndone, rdy_pct, m_rr;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic logic [AW-1:0] a_at(int i);
        return (acc_addr.size() > i) ? acc_addr[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic drive_fifos();
        for (int k = 0; k < NF; k++) begin
            opsum_fifo_empty_i[k] = (fq[k].size() == 0);
            opsum_fifo_data_i[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : '0;
        end
    endtask

    // One clock: drive at negedge, observe before posedge, retire pop after.
    task automatic step();
        int pl;
        pl = -1;
        @(negedge clk);
        glb_ready_i = ($urandom_range(99) < rdy_pct);
        drive_fifos();
        #1;
        if (opsum_fifo_pop_o != '0) begin
            npops++;
            if (!$onehot(opsum_fifo_pop_o) || glb_we_o) viol++;
            for (int k = 0; k < NF; k++)
                if (opsum_fifo_pop_o[k]) begin
                    pl = k;
                    if (!tb_act[k] || fq[k].size() == 0) viol++;
                end
        end
        if (glb_we_o && glb_ready_i && !clear_i) begin
            acc_addr.push_back(glb_addr_o);
            acc_data.push_back(glb_wdata_o);
        end
        if (done_o) ndone++;
        @(posedge clk); #1;
        if (pl >= 0 && fq[pl].size() > 0) void'(fq[pl].pop_front());
    endtask

    task automatic clr_book();
        acc_addr.delete(); acc_data.delete();
        viol = 0; npops = 0; ndone = 0;
    endtask

    task automatic fill(int nl, int nw);
        for (int k = 0; k < NF; k++) begin
            fq[k].delete();
            if (k < nl) for (int w = 0; w < nw; w++) fq[k].push_back(16'($urandom));
        end
    endtask

    task automatic do_clear();
        clear_i = 1; step(); clear_i = 0; m_rr = 0;
    endtask

    task automatic set_act(logic [1:0] lt, int oc);
        for (int k = 0; k < NF; k++)
            tb_act[k] = (lt == PW) ? (k < oc) : (lt == DWL) ? (k < DWCH) : 1'b0;
    endtask

    // Reference: list every write the tile should produce, given the data
    // sitting in the FIFOs now. Incomplete means the drain starves.
    task automatic model(int el, logic [AW-1:0] base, logic [AW-1:0] stride, output bit complete);
        int rem[NF], tk[NF];
        int left, pick, c;
        bit run;
        exp_addr.delete(); exp_data.delete();
        for (int k = 0; k < NF; k++) begin rem[k] = tb_act[k] ? el : 0; tk[k] = 0; end
        complete = 0; run = 1;
        while (run) begin
            left = 0;
            for (int k = 0; k < NF; k++) left += rem[k];
            pick = -1;
            for (int i = 0; i < NF; i++) begin
                c = (m_rr + i) % NF;
                if (pick < 0 && rem[c] > 0 && tk[c] < fq[c].size()) pick = c;
            end
            if (left == 0) begin complete = 1; run = 0; end
            else if (pick < 0) run = 0;
            else begin
                exp_addr.push_back(base + AW'(pick) * stride + AW'(tk[pick]));
                exp_data.push_back(fq[pick][tk[pick]]);
                tk[pick]++; rem[pick]--;
                m_rr = (pick + 1) % NF;
            end
        end
    endtask

    task automatic run_tile(string nm, logic [1:0] lt, int oc, int el, logic [AW-1:0] base,
                            logic [AW-1:0] stride, int rdy, output int nw, output int nd);
        bit complete;
        int cyc, budget;
        set_act(lt, oc);
        model(el, base, stride, complete);
        clr_book();
        rdy_pct = rdy;
        layer_type_i = lt; OC_real_i = 8'(oc); elems_per_oc_i = CW'(el);
        base_addr_i = base; oc_stride_i = stride;
        start_i = 1; step(); start_i = 0;
        // Scramble configuration: the tile must run on the latched copy.
        layer_type_i = 2'($urandom); OC_real_i = 8'($urandom);
        elems_per_oc_i = CW'($urandom); base_addr_i = $urandom; oc_stride_i = $urandom;
        budget = 40 + 20 * exp_addr.size();
        cyc = 0;
        while (ndone == 0 && cyc < budget) begin step(); cyc++; end
        chk({nm, " writes"}, acc_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < acc_addr.size(); i++) begin
            chk({nm, " addr"}, acc_addr[i], exp_addr[i]);
            chk({nm, " data"}, acc_data[i], exp_data[i]);
        end
        chk({nm, " done"}, ndone, complete ? 1 : 0);
        chk({nm, " pop rules"}, viol, 0);
        chk({nm, " busy after"}, busy_o, complete ? 1'b0 : 1'b1);
        nw = acc_addr.size(); nd = ndone;
        if (!complete) do_clear();
    endtask

    typedef struct {
        string nm; logic [1:0] lt; int oc; int el; logic [AW-1:0] base; logic [AW-1:0] stride;
        int fl; int fw; int rdy; int exp_nw; int exp_done;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic [AW-1:0] t1[8];
        int nw, nd, lt_sel, el;
        logic [1:0] lt;

        rst_n = 0; start_i = 0; clear_i = 0; layer_type_i = 0; OC_real_i = 0;
        elems_per_oc_i = 0; base_addr_i = 0; oc_stride_i = 0; glb_ready_i = 0;
        rdy_pct = 100; m_rr = 0; tb_act = '0;
        clr_book(); fill(0, 0); drive_fifos();
        #23 rst_n = 1;
        @(negedge clk); #1;
        chk("rst busy", busy_o, 0);
        chk("rst we", glb_we_o, 0);
        chk("rst done", done_o, 0);
        chk("rst pop", opsum_fifo_pop_o, 0);
        chk("rst addr", glb_addr_o, 0);
        chk("rst wdata", glb_wdata_o, 0);

        // Pointwise, 4 lanes x 2 words, all FIFOs full.
        t1 = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h101, 32'h111, 32'h121, 32'h131};
        fill(NF, 4);
        run_tile("pw4x2", PW, 4, 2, 32'h100, 32'h10, 100, nw, nd);
        for (int i = 0; i < 8; i++) chk("pw4x2 order", a_at(i), t1[i]);
        for (int k = 4; k < NF; k++) chk("pw4x2 untouched", fq[k].size(), 4);

        vt[0] = '{"dw e1", DWL, 0, 1, 32'h0, 32'h20, 16, 2, 100, 10, 1};
        vt[1] = '{"oc0", PW, 0, 3, 32'h50, 32'h8, 32, 3, 100, 0, 1};
        vt[2] = '{"elems0", PW, 5, 0, 32'h50, 32'h8, 32, 3, 100, 0, 1};
        vt[3] = '{"bad lt", 2'd3, 8, 2, 32'h50, 32'h8, 32, 3, 100, 0, 1};
        vt[4] = '{"oc clamp", PW, 40, 1, 32'h1000, 32'h40, 32, 1, 60, 32, 1};
        vt[5] = '{"wrap", PW, 3, 2, 32'hFFFF_FFF0, 32'h8000_0000, 32, 2, 50, 6, 1};
        vt[6] = '{"dw e3", DWL, 0, 3, 32'h300, 32'h3, 10, 3, 70, 30, 1};
        vt[7] = '{"starve", PW, 6, 2, 32'h0, 32'h10, 4, 2, 100, 8, 0};
        for (int v = 0; v < 8; v++) begin
            fill(vt[v].fl, vt[v].fw);
            run_tile(vt[v].nm, vt[v].lt, vt[v].oc, vt[v].el, vt[v].base, vt[v].stride,
                     vt[v].rdy, nw, nd);
            chk({vt[v].nm, " n"}, nw, vt[v].exp_nw);
            chk({vt[v].nm, " d"}, nd, vt[v].exp_done);
        end
        for (int k = DWCH; k < 16; k++) chk("dw e3 lane idle", fq[k].size(), 0);

        // Back-pressure: ready held low for 5 WRITE cycles.
        do_clear(); fill(0, 0); clr_book();
        fq[0].push_back(16'hBEEF); fq[0].push_back(16'h1234);
        set_act(PW, 1); rdy_pct = 0;
        layer_type_i = PW; OC_real_i = 1; elems_per_oc_i = 1; base_addr_i = 32'h2000; oc_stride_i = 4;
        start_i = 1; step(); start_i = 0;
        for (int i = 0; i < 6 && !glb_we_o; i++) step();
        chk("bp we", glb_we_o, 1);
        repeat (5) begin
            step();
            chk("bp hold we", glb_we_o, 1);
            chk("bp hold addr", glb_addr_o, 32'h2000);
            chk("bp hold data", glb_wdata_o, 16'hBEEF);
        end
        rdy_pct = 100; step();
        chk("bp accepts", acc_addr.size(), 1);
        for (int i = 0; i < 4 && ndone == 0; i++) step();
        chk("bp done", ndone, 1);
        chk("bp pops", npops, 1);
        chk("bp fifo left", fq[0].size(), 1);
        chk("bp rules", viol, 0);

        // Starvation and rr wrap: only lane 2 has data, then lane 0 fills.
        do_clear(); fill(0, 0); clr_book();
        fq[2].push_back(16'h2222);
        set_act(PW, 4); rdy_pct = 100;
        layer_type_i = PW; OC_real_i = 4; elems_per_oc_i = 1; base_addr_i = 32'h40; oc_stride_i = 32'h100;
        start_i = 1; step(); start_i = 0;
        for (int i = 0; i < 6 && acc_addr.size() < 1; i++) step();
        chk("sv first", a_at(0), 32'h240);
        repeat (5) step();
        chk("sv idle pops", npops, 1);
        chk("sv busy", busy_o, 1);
        fq[0].push_back(16'h0A0A);
        for (int i = 0; i < 6 && acc_addr.size() < 2; i++) step();
        chk("sv wrap lane0", a_at(1), 32'h40);
        chk("sv wrap data", (acc_data.size() > 1) ? acc_data[1] : 16'h0, 16'h0A0A);
        fq[1].push_back(16'h1111); fq[3].push_back(16'h3333);
        for (int i = 0; i < 20 && ndone == 0; i++) step();
        chk("sv lane1", a_at(2), 32'h140);
        chk("sv lane3", a_at(3), 32'h340);
        chk("sv done", ndone, 1);
        chk("sv rules", viol, 0);

        // Clear during WRITE with ready high: write dropped, tile restarts.
        do_clear(); fill(2, 2); clr_book();
        set_act(PW, 2); rdy_pct = 100;
        layer_type_i = PW; OC_real_i = 2; elems_per_oc_i = 2; base_addr_i = 32'h800; oc_stride_i = 32'h10;
        start_i = 1; step(); start_i = 0;
        for (int i = 0; i < 6 && !glb_we_o; i++) step();
        chk("clr in write", glb_we_o, 1);
        clear_i = 1; step(); clear_i = 0; m_rr = 0;
        chk("clr no write", acc_addr.size(), 0);
        chk("clr busy", busy_o, 0);
        chk("clr we", glb_we_o, 0);
        chk("clr addr", glb_addr_o, 0);
        fill(2, 2);
        run_tile("redo", PW, 2, 2, 32'h800, 32'h10, 100, nw, nd);
        chk("redo first", a_at(0), 32'h800);

        // Randomized tiles against the model.
        for (int r = 0; r < 10; r++) begin
            lt_sel = $urandom_range(0, 2);
            lt = (lt_sel == 0) ? PW : (lt_sel == 1) ? DWL : 2'd2;
            el = $urandom_range(0, 3);
            for (int k = 0; k < NF; k++) begin
                fq[k].delete();
                repeat ($urandom_range(0, el + 1)) fq[k].push_back(16'($urandom));
            end
            run_tile("rand", lt, $urandom_range(0, 40), el, $urandom, $urandom,
                     $urandom_range(50, 100), nw, nd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
